// File: rtl/mem_controler_pkg.sv
// Shared constants and FSM state encoding for the
// 32-bit over 16-bit RAM memory controller.
package mem_controler_pkg;

  localparam int ADDR_W  = 18;
  localparam int RAM_DW  = 16;
  localparam int WORD_DW = 2 * RAM_DW;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } state_t;

endpackage

// File: rtl/mem_controler_if.sv
// CPU-side request bundle: instruction fetch port
// plus the direction/enable/address of the data port.
interface mem_controler_if;
  import mem_controler_pkg::*;

  logic               if_mc_en;
  logic [ADDR_W-1:0]  if_mc_addr;
  logic [WORD_DW-1:0] mc_if_data;
  logic               mem_mc_rw;
  logic               mem_mc_en;
  logic [ADDR_W-1:0]  mem_mc_addr;

  modport master (
    output if_mc_en,
    output if_mc_addr,
    input  mc_if_data,
    output mem_mc_rw,
    output mem_mc_en,
    output mem_mc_addr
  );

  modport slave (
    input  if_mc_en,
    input  if_mc_addr,
    output mc_if_data,
    input  mem_mc_rw,
    input  mem_mc_en,
    input  mem_mc_addr
  );

endinterface

// File: rtl/mem_controler.sv
// Splits each 32-bit CPU access into two 16-bit RAM
// cycles; data port has priority over fetch.
module mem_controler #(
  parameter int ADDR_W  = 18,
  parameter int RAM_DW  = 16,
  parameter int WORD_DW = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_controler_if.slave      bus,
  inout  wire [WORD_DW-1:0]   mem_mc_data,
  output logic [ADDR_W-1:0]   mc_ram_addr,
  output logic                mc_ram_wre,
  inout  wire [RAM_DW-1:0]    mc_ram_data
);
  import mem_controler_pkg::*;

  state_t              state_q;
  state_t              state_d;
  logic                wr_q;
  logic                fetch_q;
  logic [ADDR_W-1:0]   base_q;
  logic [WORD_DW-1:0]  wdata_q;
  logic [WORD_DW-1:0]  rdata_q;
  logic [RAM_DW-1:0]   lo_q;
  logic [RAM_DW-1:0]   wr_half;
  logic                req;

  assign req = bus.mem_mc_en | bus.if_mc_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = LO;
      LO:   state_d = HI;
      HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_q           <= 1'b0;
      fetch_q        <= 1'b0;
      base_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      lo_q           <= '0;
      mc_ram_addr    <= '0;
      mc_ram_wre     <= 1'b0;
      bus.mc_if_data <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.mem_mc_en) begin
            wr_q        <= bus.mem_mc_rw;
            fetch_q     <= 1'b0;
            base_q      <= bus.mem_mc_addr;
            wdata_q     <= mem_mc_data;
            mc_ram_addr <= bus.mem_mc_addr;
            mc_ram_wre  <= bus.mem_mc_rw;
          end else if (bus.if_mc_en) begin
            wr_q        <= 1'b0;
            fetch_q     <= 1'b1;
            base_q      <= bus.if_mc_addr;
            mc_ram_addr <= bus.if_mc_addr;
            mc_ram_wre  <= 1'b0;
          end
        end
        LO: begin
          if (!wr_q) lo_q <= mc_ram_data;
          // address arithmetic wraps at the top of RAM
          mc_ram_addr <= base_q + ADDR_W'(1);
        end
        HI: begin
          mc_ram_wre <= 1'b0;
          if (!wr_q) begin
            if (fetch_q)
              bus.mc_if_data <= {mc_ram_data, lo_q};
            else
              rdata_q <= {mc_ram_data, lo_q};
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_half = (state_q == HI) ?
                   wdata_q[WORD_DW-1:RAM_DW] :
                   wdata_q[RAM_DW-1:0];

  assign mc_ram_data = mc_ram_wre ? wr_half : 'z;

  assign mem_mc_data =
    (bus.mem_mc_en && !bus.mem_mc_rw) ? rdata_q : 'z;

endmodule

// File: tb/tb_mem_controler.sv
// Directed bench for mem_controler with a RAM model
// and a queue of expected results.
module tb_mem_controler;

  logic        clk;
  logic        rst_n;
  wire  [31:0] mem_mc_data;
  wire  [15:0] mc_ram_data;
  logic [17:0] mc_ram_addr;
  logic        mc_ram_wre;

  logic        ram_oe;
  logic        tb_oe;
  logic [31:0] tb_wdata;
  logic [15:0] ram [0:262143];

  logic [31:0] exp_q [$];
  int          n_vec;
  int          n_err;

  mem_controler_if bus ();

  mem_controler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_mc_data (mem_mc_data),
    .mc_ram_addr (mc_ram_addr),
    .mc_ram_wre  (mc_ram_wre),
    .mc_ram_data (mc_ram_data)
  );

  pullup pu_ram (mc_ram_data);
  pullup pu_mem (mem_mc_data);

  assign mc_ram_data =
    (ram_oe && !mc_ram_wre) ? ram[mc_ram_addr] : 'z;
  assign mem_mc_data = tb_oe ? tb_wdata : 'z;

  always @(posedge clk)
    if (mc_ram_wre) ram[mc_ram_addr] = mc_ram_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag,
                        input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed %h expected <empty>",
             tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ram_oe = 1'b0;
    tb_oe = 1'b0;
    tb_wdata = '0;
    bus.if_mc_en = 1'b0;
    bus.if_mc_addr = '0;
    bus.mem_mc_en = 1'b0;
    bus.mem_mc_rw = 1'b0;
    bus.mem_mc_addr = '0;
    ram[18'h10] = 16'hBEEF;
    ram[18'h11] = 16'hDEAD;
    ram[18'h30] = 16'h1111;
    ram[18'h31] = 16'h2222;
    ram[18'h40] = 16'h3333;
    ram[18'h41] = 16'h4444;
    ram[18'h3FFFF] = 16'hAAAA;
    ram[18'h00000] = 16'h5555;

    // reset state
    #2;
    chk("rst_addr", 32'(mc_ram_addr), 32'h0);
    chk("rst_wre", 32'(mc_ram_wre), 32'h0);
    chk("rst_ifdata", bus.mc_if_data, 32'h0);
    chk("rst_ramz", 32'(mc_ram_data), 32'hFFFF);
    chk("rst_memz", mem_mc_data, 32'hFFFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    ram_oe = 1'b1;

    // fetch at 0x10, request dropped after grant
    @(negedge clk);
    bus.if_mc_en = 1'b1;
    bus.if_mc_addr = 18'h10;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    bus.if_mc_en = 1'b0;
    chk("f_lo_addr", 32'(mc_ram_addr), 32'h10);
    chk("f_lo_wre", 32'(mc_ram_wre), 32'h0);
    chk("f_lo_bus", 32'(mc_ram_data), 32'hBEEF);
    @(negedge clk);
    chk("f_hi_addr", 32'(mc_ram_addr), 32'h11);
    chk("f_hi_wre", 32'(mc_ram_wre), 32'h0);
    chk("f_ifdata_hold", bus.mc_if_data, 32'h0);
    @(negedge clk);
    chk_sb("f_ifdata", bus.mc_if_data);

    // write 0x12345678 to 0x20
    bus.mem_mc_en = 1'b1;
    bus.mem_mc_rw = 1'b1;
    bus.mem_mc_addr = 18'h20;
    tb_oe = 1'b1;
    tb_wdata = 32'h12345678;
    exp_q.push_back(32'h5678);
    exp_q.push_back(32'h1234);
    @(negedge clk);
    bus.mem_mc_en = 1'b0;
    tb_oe = 1'b0;
    tb_wdata = 32'hFFFF0000;
    chk("w_lo_wre", 32'(mc_ram_wre), 32'h1);
    chk("w_lo_addr", 32'(mc_ram_addr), 32'h20);
    chk("w_lo_bus", 32'(mc_ram_data), 32'h5678);
    @(negedge clk);
    chk("w_hi_wre", 32'(mc_ram_wre), 32'h1);
    chk("w_hi_addr", 32'(mc_ram_addr), 32'h21);
    chk("w_hi_bus", 32'(mc_ram_data), 32'h1234);
    @(negedge clk);
    chk("w_end_wre", 32'(mc_ram_wre), 32'h0);
    chk_sb("w_ram20", 32'(ram[18'h20]));
    chk_sb("w_ram21", 32'(ram[18'h21]));
    chk("w_ifdata_hold", bus.mc_if_data,
        32'hDEADBEEF);

    // data read and fetch raised together
    bus.mem_mc_en = 1'b1;
    bus.mem_mc_rw = 1'b0;
    bus.mem_mc_addr = 18'h30;
    bus.if_mc_en = 1'b1;
    bus.if_mc_addr = 18'h40;
    exp_q.push_back(32'h22221111);
    exp_q.push_back(32'h44443333);
    @(negedge clk);
    chk("p_lo_addr", 32'(mc_ram_addr), 32'h30);
    chk("p_lo_wre", 32'(mc_ram_wre), 32'h0);
    @(negedge clk);
    chk("p_hi_addr", 32'(mc_ram_addr), 32'h31);
    chk("p_hi_wre", 32'(mc_ram_wre), 32'h0);
    @(negedge clk);
    chk_sb("p_memdata", mem_mc_data);
    bus.mem_mc_en = 1'b0;
    #1;
    chk("p_memz", mem_mc_data, 32'hFFFFFFFF);
    @(negedge clk);
    bus.if_mc_en = 1'b0;
    chk("p_f_addr", 32'(mc_ram_addr), 32'h40);
    chk("p_f_wre", 32'(mc_ram_wre), 32'h0);
    @(negedge clk);
    chk("p_f_hi_addr", 32'(mc_ram_addr), 32'h41);
    @(negedge clk);
    chk_sb("p_ifdata", bus.mc_if_data);

    // read across the top of the address space
    bus.mem_mc_en = 1'b1;
    bus.mem_mc_rw = 1'b0;
    bus.mem_mc_addr = 18'h3FFFF;
    exp_q.push_back(32'h5555AAAA);
    @(negedge clk);
    chk("wr_lo_addr", 32'(mc_ram_addr), 32'h3FFFF);
    @(negedge clk);
    chk("wr_hi_addr", 32'(mc_ram_addr), 32'h0);
    @(negedge clk);
    chk_sb("wr_memdata", mem_mc_data);
    bus.mem_mc_en = 1'b0;

    // reset in the middle of a write's HI cycle
    @(negedge clk);
    bus.mem_mc_en = 1'b1;
    bus.mem_mc_rw = 1'b1;
    bus.mem_mc_addr = 18'h50;
    tb_oe = 1'b1;
    tb_wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.mem_mc_en = 1'b0;
    tb_oe = 1'b0;
    @(negedge clk);
    chk("r_hi_wre", 32'(mc_ram_wre), 32'h1);
    chk("r_hi_bus", 32'(mc_ram_data), 32'hCAFE);
    ram_oe = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("r_wre", 32'(mc_ram_wre), 32'h0);
    chk("r_addr", 32'(mc_ram_addr), 32'h0);
    chk("r_ifdata", bus.mc_if_data, 32'h0);
    chk("r_ramz", 32'(mc_ram_data), 32'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    ram_oe = 1'b1;

    // controller must be idle: fetch completes on time
    bus.if_mc_en = 1'b1;
    bus.if_mc_addr = 18'h10;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    bus.if_mc_en = 1'b0;
    chk("r_f_addr", 32'(mc_ram_addr), 32'h10);
    @(negedge clk);
    @(negedge clk);
    chk_sb("r_f_ifdata", bus.mc_if_data);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_controler.md
MEM_CONTROLER -- requirements
Module: mem_controler

Interface
REQ-001 Parameter ADDR_W, default 18: RAM and request address width.
REQ-002 Parameter RAM_DW, default 16: RAM data width.
REQ-003 Parameter WORD_DW, default 32: CPU word width, always equal to 2*RAM_DW.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 if_mc_en  in  1  instruction-fetch read request.
REQ-008 if_mc_addr  in  18  fetch RAM base address.
REQ-009 mc_if_data  out  32  fetched word, registered.
REQ-010 mem_mc_rw  in  1  data-port direction: 1 = write, 0 = read.
REQ-011 mem_mc_en  in  1  data-port request.
REQ-012 mem_mc_addr  in  18  data-port RAM base address.
REQ-013 mem_mc_data  inout  32  write data in, or read data out.
REQ-014 mc_ram_addr  out  18  RAM half-word address, registered.
REQ-015 mc_ram_wre  out  1  RAM write enable, active-high, registered.
REQ-016 mc_ram_data  inout  16  RAM data bus.

Function
REQ-017 Each 32-bit access SHALL be two RAM half-word cycles: low half [15:0] at base, high half [31:16] at base+1.
REQ-018 base+1 SHALL wrap modulo 2^18, so 0x3FFFF+1 = 0x00000.
REQ-019 FSM states SHALL be IDLE, LO and HI, with transitions IDLE->LO on any request, LO->HI, and HI->IDLE.
REQ-020 In IDLE, the block SHALL grant mem_mc_en over if_mc_en when both are high, and latch op, base and write data at the grant edge.
REQ-021 A fetch requested while a data access is granted SHALL be served after that access completes, provided if_mc_en is still high.
REQ-022 In LO, mc_ram_addr SHALL equal base; in HI, it SHALL equal base+1.
REQ-023 mc_ram_wre SHALL be 1 in LO and HI of a write only, and 0 otherwise.
REQ-024 The block SHALL drive mc_ram_data only while mc_ram_wre=1: latched [15:0] in LO, latched [31:16] in HI; otherwise high-Z.
REQ-025 RAM read data SHALL be treated as valid combinationally in the same cycle as its address.
REQ-026 On a read, the block SHALL capture the low half at the end of LO and the high half at the end of HI.
REQ-027 On a read, the destination register SHALL update at the HI->IDLE edge.
REQ-028 Read latency SHALL be 3 rising edges from the grant edge.
REQ-029 A new request MAY be granted in the IDLE cycle immediately after.
REQ-030 mc_if_data SHALL hold the last fetched word until the next fetch completes.
REQ-031 The block SHALL drive mem_mc_data with the data-read register while mem_mc_en=1 and mem_mc_rw=0; otherwise high-Z.
REQ-032 Requests deasserted mid-transaction SHALL NOT abort it; the access SHALL run to HI.
REQ-033 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-034 On reset low, the state SHALL go to IDLE immediately.
REQ-035 On reset low, mc_ram_addr, mc_ram_wre, mc_if_data and the data-read register SHALL go to 0, and both inout buses SHALL go to high-Z.
REQ-036 Reset during LO or HI SHALL abandon the access; a partial write MAY leave one half written.

Structure
REQ-037 A shared package SHALL hold the state enum (IDLE, LO, HI) and the ADDR_W, RAM_DW and WORD_DW constants.
REQ-038 The design SHALL be a single module with no sub-module; tristate drivers SHALL be continuous assigns.

Verification
REQ-039 Reset test: reset=0 mid-HI -> state IDLE, mc_ram_wre=0, mc_if_data=0, mc_ram_data=Z.
REQ-040 Fetch test: RAM[0x10]=0xBEEF, RAM[0x11]=0xDEAD, if_mc_en=1, if_mc_addr=0x10 -> mc_ram_addr 0x10 then 0x11, mc_if_data=0xDEADBEEF after 3 edges.
REQ-041 Write test: mem_mc_en=1, rw=1, addr=0x20, data=0x12345678 -> wre=1 twice; RAM[0x20]=0x5678, RAM[0x21]=0x1234.
REQ-042 Priority test: both requests raised at 0x30 (mem read) and 0x40 -> data port served first, then fetch; mem_mc_data valid 3 edges, mc_if_data 6 edges after start.
REQ-043 Wrap test: mem read at 0x3FFFF -> second half-word address is 0x00000.
REQ-044 Bus test: mem_mc_en=0 -> mem_mc_data=Z; during a read, mc_ram_data is never driven by the block.
